// File: rtl/cb_mode_switch_seq.sv
// Purpose: sequences a safe-mode reconfiguration: halt all harts, apply mode/config, resume, await software end.
// Latency: launch-to-done minimum 1+1+SYNC_CYCLES+1+1+1 cycles with harts answering in one cycle.
// Backpressure: start edges outside IDLE are dropped (no queuing); HALT/RESUME bounded by TIMEOUT_CYCLES -> ERROR.
module cb_mode_switch_seq #(
  parameter int NHARTS         = 3,
  parameter int SYNC_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              safe_mode_i,
  input  logic [1:0]        safe_config_i,
  input  logic [2:0]        master_core_i,
  input  logic [NHARTS-1:0] debug_mode_i,
  input  logic [NHARTS-1:0] sleep_i,
  input  logic              end_sw_i,
  input  logic              err_clear_i,
  output logic [NHARTS-1:0] debug_req_o,
  output logic              safe_mode_o,
  output logic [1:0]        safe_config_o,
  output logic [2:0]        master_core_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [2:0]        state_o
);

  // Counter covers both the halt/resume timeout window and the sync hold window.
  localparam int            CNT_MAX   = (TIMEOUT_CYCLES > SYNC_CYCLES) ? TIMEOUT_CYCLES : SYNC_CYCLES;
  localparam int            CW        = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HALT   = 3'd1,
    ST_APPLY  = 3'd2,
    ST_RESUME = 3'd3,
    ST_RUN    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  state_t            r_state;
  logic              r_start_q;
  logic [CW-1:0]     r_cnt;
  logic              r_shadow_mode;
  logic [1:0]        r_shadow_cfg;
  logic [2:0]        r_shadow_master;
  logic [NHARTS-1:0] r_debug_req;
  logic              r_safe_mode;
  logic [1:0]        r_safe_cfg;
  logic [2:0]        r_master;
  logic              r_done;
  logic              r_error;

  logic              w_launch;
  logic              w_all_halted;
  logic              w_any_halted;
  logic              w_all_asleep;
  logic [CW-1:0]     w_cnt_inc;

  assign w_launch     = start_i & ~r_start_q;
  assign w_all_halted = &debug_mode_i;
  assign w_any_halted = |debug_mode_i;
  assign w_all_asleep = &sleep_i;
  // Saturating increment: the counter parks at its maximum instead of wrapping.
  assign w_cnt_inc    = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CW'(1);

  // Start level delayed by one cycle for rising-edge detection, tracked in every state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_start_q <= 1'b0;
    end else begin
      r_start_q <= start_i;
    end
  end

  // Sequencer FSM; debug request, applied config, done and error are all registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_shadow_mode   <= 1'b0;
      r_shadow_cfg    <= '0;
      r_shadow_master <= '0;
      r_debug_req     <= '0;
      r_safe_mode     <= 1'b0;
      r_safe_cfg      <= '0;
      r_master        <= '0;
      r_done          <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_shadow_mode   <= safe_mode_i;
            r_shadow_cfg    <= safe_config_i;
            r_shadow_master <= master_core_i;
            r_cnt           <= '0;
            r_debug_req     <= '1;
            r_state         <= ST_HALT;
          end
        end
        ST_HALT: begin
          // All-halted wins over timeout when both land in the same cycle.
          if (w_all_halted) begin
            r_cnt       <= '0;
            r_safe_mode <= r_shadow_mode;
            r_safe_cfg  <= r_shadow_cfg;
            r_master    <= r_shadow_master;
            r_state     <= ST_APPLY;
          end else if (r_cnt == TO_LAST) begin
            r_cnt       <= '0;
            r_debug_req <= '0;
            r_error     <= 1'b1;
            r_state     <= ST_ERROR;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_APPLY: begin
          // Harts stay halted while the new configuration settles in the wrapper.
          if (r_cnt == SYNC_LAST) begin
            r_cnt       <= '0;
            r_debug_req <= '0;
            r_state     <= ST_RESUME;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_RESUME: begin
          if (!w_any_halted) begin
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end else if (r_cnt == TO_LAST) begin
            r_cnt   <= '0;
            r_error <= 1'b1;
            r_state <= ST_ERROR;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_RUN: begin
          if (end_sw_i && w_all_asleep) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        ST_ERROR: begin
          // Applied outputs are left untouched; only an explicit clear leaves this state.
          if (err_clear_i) begin
            r_error <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_cnt       <= '0;
          r_debug_req <= '0;
          r_error     <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign debug_req_o   = r_debug_req;
  assign safe_mode_o   = r_safe_mode;
  assign safe_config_o = r_safe_cfg;
  assign master_core_o = r_master;
  assign done_o        = r_done;
  assign error_o       = r_error;
  assign state_o       = r_state;
  assign busy_o        = (r_state == ST_HALT)   || (r_state == ST_APPLY) ||
                         (r_state == ST_RESUME) || (r_state == ST_RUN)   ||
                         (r_state == ST_DONE);

endmodule

// File: tb/tb_cb_mode_switch_seq.sv
// Purpose: self-checking bench for cb_mode_switch_seq; applied configs scoreboarded at APPLY entry.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: every wait on the DUT is bounded by a cycle budget.
module tb_cb_mode_switch_seq;

  localparam int NHARTS = 3;
  localparam int SYNC   = 4;
  localparam int TO     = 1024;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b1;
  logic              start_i = 1'b0;
  logic              safe_mode_i = 1'b0;
  logic [1:0]        safe_config_i = '0;
  logic [2:0]        master_core_i = '0;
  logic [NHARTS-1:0] debug_mode_i = '0;
  logic [NHARTS-1:0] sleep_i = '0;
  logic              end_sw_i = 1'b0;
  logic              err_clear_i = 1'b0;
  logic [NHARTS-1:0] debug_req_o;
  logic              safe_mode_o;
  logic [1:0]        safe_config_o;
  logic [2:0]        master_core_o;
  logic              busy_o;
  logic              done_o;
  logic              error_o;
  logic [2:0]        state_o;

  typedef struct packed {
    logic       mode;
    logic [1:0] cfg;
    logic [2:0] master;
  } cfg_t;

  cfg_t exp_q[$];
  cfg_t last_cfg = '0;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk_i = ~clk_i;

  cb_mode_switch_seq #(
    .NHARTS        (NHARTS),
    .SYNC_CYCLES   (SYNC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .safe_mode_i  (safe_mode_i),
    .safe_config_i(safe_config_i),
    .master_core_i(master_core_i),
    .debug_mode_i (debug_mode_i),
    .sleep_i      (sleep_i),
    .end_sw_i     (end_sw_i),
    .err_clear_i  (err_clear_i),
    .debug_req_o  (debug_req_o),
    .safe_mode_o  (safe_mode_o),
    .safe_config_o(safe_config_o),
    .master_core_o(master_core_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .state_o      (state_o)
  );

  function automatic cfg_t applied();
    return {safe_mode_o, safe_config_o, master_core_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a fresh start rising edge with the given request; optionally records the expected apply.
  task automatic launch(input cfg_t c, input bit push);
    start_i = 1'b0;
    tick();
    safe_mode_i   = c.mode;
    safe_config_i = c.cfg;
    master_core_i = c.master;
    start_i       = 1'b1;
    if (push) exp_q.push_back(c);
  endtask

  // Steps until state_o == s or the budget runs out; auto_hart makes harts follow debug_req one cycle later.
  task automatic wait_state(input logic [2:0] s, input int budget, input bit auto_hart, output bit ok);
    int cyc;
    cyc = 0;
    ok  = 1'b1;
    while (state_o !== s) begin
      if (cyc >= budget) begin
        ok = 1'b0;
        return;
      end
      tick();
      cyc++;
      if (auto_hart) debug_mode_i = debug_req_o;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    n_total++; if ({debug_req_o, safe_mode_o, safe_config_o, master_core_o, busy_o, done_o, error_o, state_o} !== 15'h0)
      $display("FAIL reset_outputs: got %0h want 0", {debug_req_o, safe_mode_o, safe_config_o, master_core_o, busy_o, done_o, error_o, state_o}); else n_pass++;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    n_total++; if (state_o !== 3'd0 || busy_o !== 1'b0) $display("FAIL reset_release_idle: got state %0d busy %0b want 0 0", state_o, busy_o); else n_pass++;
  endtask

  task automatic test_basic();
    cfg_t c, e;
    int   k;
    c = {1'b1, 2'b10, 3'b001};
    launch(c, 1'b1);
    tick();
    n_total++; if (state_o !== 3'd1) $display("FAIL basic_halt_state: got %0d want 1", state_o); else n_pass++;
    n_total++; if (debug_req_o !== 3'b111 || busy_o !== 1'b1) $display("FAIL basic_halt_req: got req %b busy %b want 111 1", debug_req_o, busy_o); else n_pass++;
    n_total++; if (applied() !== 6'h0) $display("FAIL basic_no_early_apply: got %0h want 0", applied()); else n_pass++;
    safe_mode_i   = 1'b0;
    safe_config_i = 2'b01;
    master_core_i = 3'b110;
    tick();
    tick();
    debug_mode_i = '1;
    tick();
    n_total++; if (state_o !== 3'd2) $display("FAIL basic_apply_state: got %0d want 2", state_o); else n_pass++;
    e = exp_q.pop_front();
    n_total++; if (applied() !== e) $display("FAIL basic_apply_cfg: got %0h want %0h", applied(), e); else n_pass++;
    k = 0;
    while (state_o == 3'd2 && k < 20) begin
      k++;
      tick();
    end
    n_total++; if (k !== SYNC) $display("FAIL basic_sync_len: got %0d want %0d", k, SYNC); else n_pass++;
    n_total++; if (state_o !== 3'd3 || debug_req_o !== 3'b000) $display("FAIL basic_resume: got state %0d req %b want 3 000", state_o, debug_req_o); else n_pass++;
    debug_mode_i = '0;
    tick();
    n_total++; if (state_o !== 3'd4) $display("FAIL basic_run_state: got %0d want 4", state_o); else n_pass++;
    tick();
    tick();
    sleep_i = '1;
    tick();
    n_total++; if (state_o !== 3'd4) $display("FAIL basic_run_wait_end: got %0d want 4", state_o); else n_pass++;
    end_sw_i = 1'b1;
    tick();
    n_total++; if (state_o !== 3'd5 || done_o !== 1'b1) $display("FAIL basic_done: got state %0d done %b want 5 1", state_o, done_o); else n_pass++;
    tick();
    n_total++; if (state_o !== 3'd0 || done_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL basic_back_idle: got state %0d done %b busy %b want 0 0 0", state_o, done_o, busy_o); else n_pass++;
    n_total++; if (applied() !== c) $display("FAIL basic_cfg_kept: got %0h want %0h", applied(), c); else n_pass++;
    end_sw_i = 1'b0;
    sleep_i  = '0;
    last_cfg = c;
  endtask

  task automatic test_timeout();
    cfg_t c;
    int   k;
    c = {1'b0, 2'b01, 3'b101};
    launch(c, 1'b0);
    debug_mode_i = 3'b011;
    tick();
    k = 0;
    while (state_o == 3'd1 && k < 2000) begin
      k++;
      tick();
    end
    n_total++; if (k !== TO) $display("FAIL timeout_halt_len: got %0d want %0d", k, TO); else n_pass++;
    n_total++; if (state_o !== 3'd6 || error_o !== 1'b1) $display("FAIL timeout_error: got state %0d err %b want 6 1", state_o, error_o); else n_pass++;
    n_total++; if (debug_req_o !== 3'b000 || busy_o !== 1'b0) $display("FAIL timeout_req_busy: got req %b busy %b want 000 0", debug_req_o, busy_o); else n_pass++;
    n_total++; if (applied() !== last_cfg) $display("FAIL timeout_cfg_kept: got %0h want %0h", applied(), last_cfg); else n_pass++;
    start_i = 1'b0;
    tick();
    start_i = 1'b1;
    tick();
    n_total++; if (state_o !== 3'd6) $display("FAIL timeout_start_ignored: got %0d want 6", state_o); else n_pass++;
    err_clear_i = 1'b1;
    tick();
    err_clear_i = 1'b0;
    n_total++; if (state_o !== 3'd0 || error_o !== 1'b0) $display("FAIL timeout_clear: got state %0d err %b want 0 0", state_o, error_o); else n_pass++;
    tick();
    n_total++; if (state_o !== 3'd0) $display("FAIL timeout_no_launch_held: got %0d want 0", state_o); else n_pass++;
    start_i      = 1'b0;
    debug_mode_i = '0;
  endtask

  task automatic test_run_gating();
    cfg_t c, e;
    bit   ok;
    c = {1'b1, 2'b11, 3'b010};
    launch(c, 1'b1);
    wait_state(3'd2, 20, 1'b1, ok);
    n_total++; if (!ok) $display("FAIL gate_reach_apply: got state %0d want 2", state_o); else n_pass++;
    e = exp_q.pop_front();
    n_total++; if (applied() !== e) $display("FAIL gate_apply_cfg: got %0h want %0h", applied(), e); else n_pass++;
    wait_state(3'd4, 40, 1'b1, ok);
    n_total++; if (!ok) $display("FAIL gate_reach_run: got state %0d want 4", state_o); else n_pass++;
    end_sw_i = 1'b1;
    sleep_i  = 3'b101;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (state_o !== 3'd4) $display("FAIL gate_partial_sleep: got %0d want 4", state_o); else n_pass++;
    end
    sleep_i = 3'b111;
    tick();
    n_total++; if (state_o !== 3'd5 || done_o !== 1'b1) $display("FAIL gate_done: got state %0d done %b want 5 1", state_o, done_o); else n_pass++;
    tick();
    n_total++; if (state_o !== 3'd0) $display("FAIL gate_idle: got %0d want 0", state_o); else n_pass++;
    end_sw_i = 1'b0;
    sleep_i  = '0;
    last_cfg = c;
  endtask

  task automatic test_start_ignored();
    cfg_t c, c2, e;
    bit   ok;
    c  = {1'b0, 2'b00, 3'b111};
    c2 = {1'b1, 2'b01, 3'b110};
    launch(c, 1'b1);
    wait_state(3'd2, 20, 1'b1, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || applied() !== e) $display("FAIL ign_apply_cfg: got %0h want %0h", applied(), e); else n_pass++;
    wait_state(3'd4, 40, 1'b1, ok);
    start_i = 1'b0;
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    start_i = 1'b1;
    n_total++; if (!ok || state_o !== 3'd4) $display("FAIL ign_run_toggle: got %0d want 4", state_o); else n_pass++;
    end_sw_i = 1'b1;
    sleep_i  = '1;
    tick();
    end_sw_i = 1'b0;
    sleep_i  = '0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    n_total++; if (state_o !== 3'd0 || debug_req_o !== 3'b000) $display("FAIL ign_no_relaunch: got state %0d req %b want 0 000", state_o, debug_req_o); else n_pass++;
    launch(c2, 1'b1);
    tick();
    n_total++; if (state_o !== 3'd1) $display("FAIL ign_relaunch: got %0d want 1", state_o); else n_pass++;
    debug_mode_i = debug_req_o;
    wait_state(3'd2, 20, 1'b1, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || applied() !== e) $display("FAIL ign_relaunch_cfg: got %0h want %0h", applied(), e); else n_pass++;
    wait_state(3'd4, 40, 1'b1, ok);
    end_sw_i = 1'b1;
    sleep_i  = '1;
    tick();
    tick();
    n_total++; if (!ok || state_o !== 3'd0) $display("FAIL ign_relaunch_done: got %0d want 0", state_o); else n_pass++;
    end_sw_i = 1'b0;
    sleep_i  = '0;
    start_i  = 1'b0;
    last_cfg = c2;
  endtask

  task automatic test_boundary();
    cfg_t c, e;
    int   k;
    bit   ok;
    c = {1'b1, 2'b01, 3'b011};
    launch(c, 1'b1);
    debug_mode_i = '0;
    tick();
    k = 1;
    while (k < TO && state_o == 3'd1) begin
      tick();
      k++;
    end
    n_total++; if (k !== TO || state_o !== 3'd1) $display("FAIL bound_last_halt: got k %0d state %0d want %0d 1", k, state_o, TO); else n_pass++;
    debug_mode_i = '1;
    tick();
    n_total++; if (state_o !== 3'd2 || error_o !== 1'b0) $display("FAIL bound_apply_not_error: got state %0d err %b want 2 0", state_o, error_o); else n_pass++;
    e = exp_q.pop_front();
    n_total++; if (applied() !== e) $display("FAIL bound_apply_cfg: got %0h want %0h", applied(), e); else n_pass++;
    wait_state(3'd4, 40, 1'b1, ok);
    end_sw_i = 1'b1;
    sleep_i  = '1;
    tick();
    tick();
    n_total++; if (!ok || state_o !== 3'd0) $display("FAIL bound_finish: got %0d want 0", state_o); else n_pass++;
    end_sw_i = 1'b0;
    sleep_i  = '0;
    last_cfg = c;
  endtask

  task automatic test_reset_mid();
    cfg_t c, e;
    bit   ok;
    c = {1'b0, 2'b10, 3'b100};
    launch(c, 1'b1);
    wait_state(3'd2, 20, 1'b1, ok);
    e = exp_q.pop_front();
    n_total++; if (!ok || applied() !== e) $display("FAIL rmid_apply_cfg: got %0h want %0h", applied(), e); else n_pass++;
    tick();
    n_total++; if (state_o !== 3'd2 || debug_req_o !== 3'b111) $display("FAIL rmid_in_apply: got state %0d req %b want 2 111", state_o, debug_req_o); else n_pass++;
    rst_ni = 1'b0;
    #1;
    n_total++; if ({debug_req_o, safe_mode_o, safe_config_o, master_core_o, busy_o, done_o, error_o, state_o} !== 15'h0)
      $display("FAIL rmid_async_clear: got %0h want 0", {debug_req_o, safe_mode_o, safe_config_o, master_core_o, busy_o, done_o, error_o, state_o}); else n_pass++;
    debug_mode_i = '0;
    start_i      = 1'b0;
    #2;
    rst_ni = 1'b1;
    tick();
    n_total++; if (state_o !== 3'd0 || busy_o !== 1'b0) $display("FAIL rmid_after_release: got state %0d busy %b want 0 0", state_o, busy_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_run_gating();
    test_start_ignored();
    test_boundary();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
